// File: rtl/pea_pkg.sv
// Shared definitions for the PEA output drain: FSM states, default sizes, log2 helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pea_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    CAP  = 2'd2,
    SEND = 2'd3
  } state_t;

  localparam int WIDTH_DEF           = 16;
  localparam int BUFFER_SIZE_OUT_DEF = 32;

  // Ceiling log2 with a floor of 1 bit, matching the FIFO width calculation (log2(1)=1).
  function automatic int log2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pea_desync_monitor.sv
// Flags a sticky error when the result/status FIFOs stop emptying/filling together.
// Latency: desync rises on the clock edge that registers the DESYNC_LIMIT-th consecutive mismatch.
// Backpressure: none; observes pop counts only, cleared only by reset.
module pea_desync_monitor
  import pea_pkg::*;
#(
  parameter int CNT_W        = 5,
  parameter int DESYNC_LIMIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] result_pop,
  input  logic [CNT_W-1:0] status_pop,
  output logic             desync
);

  localparam int             MW    = log2(DESYNC_LIMIT + 1);
  localparam logic [MW-1:0]  LIMIT = MW'(DESYNC_LIMIT);

  logic [MW-1:0] mis_cnt;
  logic          mismatch;
  logic          desync_q;

  // One FIFO reports data while the other is empty.
  assign mismatch = (result_pop == '0) != (status_pop == '0);

  // Saturating run-length of mismatch cycles plus the sticky error bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mis_cnt  <= '0;
      desync_q <= 1'b0;
    end else begin
      if (!mismatch) begin
        mis_cnt <= '0;
      end else if (mis_cnt != LIMIT) begin
        mis_cnt <= mis_cnt + MW'(1);
      end
      if (mismatch && (mis_cnt == LIMIT - MW'(1))) begin
        desync_q <= 1'b1;
      end
    end
  end

  assign desync = desync_q;

endmodule

// File: rtl/pea_result_drain.sv
// Pops matching result/status words, presents {status,result} with a wrapping sequence tag.
// Latency: pop strobe to out_valid is 2 cycles; one word per 3 cycles back-to-back.
// Backpressure: holds data/tag in SEND until out_ready; no further pops while stalled.
module pea_result_drain
  import pea_pkg::*;
#(
  parameter int WIDTH           = WIDTH_DEF,
  parameter int BUFFER_SIZE_OUT = BUFFER_SIZE_OUT_DEF,
  parameter int CNT_W           = log2(BUFFER_SIZE_OUT),
  parameter int SEQ_W           = 8,
  parameter int DESYNC_LIMIT    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [CNT_W-1:0]     result_pop,
  input  logic [CNT_W-1:0]     status_pop,
  input  logic [WIDTH-1:0]     result_dout,
  input  logic [WIDTH-1:0]     status_dout,
  output logic                 rd_en_result,
  output logic                 rd_en_status,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_data,
  output logic [SEQ_W-1:0]     out_seq,
  output logic [7:0]           err_count,
  output logic                 desync,
  output logic                 busy
);

  state_t             state_q, state_d;
  logic               avail;
  logic               accept;
  logic [2*WIDTH-1:0] data_q;
  logic [SEQ_W-1:0]   seq_q;
  logic [7:0]         err_q;

  pea_desync_monitor #(
    .CNT_W        (CNT_W),
    .DESYNC_LIMIT (DESYNC_LIMIT)
  ) u_desync (
    .clk        (clk),
    .rst        (rst),
    .result_pop (result_pop),
    .status_pop (status_pop),
    .desync     (desync)
  );

  assign avail  = en && !desync && (result_pop != '0) && (status_pop != '0);
  assign accept = (state_q == SEND) && out_ready;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state; strobes and status outputs decode from the current state only.
  always_comb begin
    state_d      = state_q;
    rd_en_result = 1'b0;
    rd_en_status = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (avail) state_d = POP;
      end
      POP: begin
        rd_en_result = 1'b1;
        rd_en_status = 1'b1;
        state_d      = CAP;
      end
      CAP: state_d = SEND;
      SEND: begin
        out_valid = 1'b1;
        if (out_ready) state_d = avail ? POP : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture FIFO read data the cycle after the pop strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                data_q <= '0;
    else if (state_q == CAP) data_q <= {status_dout, result_dout};
  end

  // Sequence tag and saturating error count advance on each accepted word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seq_q <= '0;
      err_q <= '0;
    end else if (accept) begin
      seq_q <= seq_q + SEQ_W'(1);
      if ((data_q[2*WIDTH-1:WIDTH] != '0) && (err_q != 8'hFF)) err_q <= err_q + 8'd1;
    end
  end

  assign out_data  = data_q;
  assign out_seq   = seq_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_pea_result_drain.sv
module tb_pea_result_drain;

  logic        clk;
  logic        rst;
  logic        en;
  logic [4:0]  result_pop;
  logic [4:0]  status_pop;
  logic [15:0] result_dout;
  logic [15:0] status_dout;
  logic        rd_en_result;
  logic        rd_en_status;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_seq;
  logic [7:0]  err_count;
  logic        desync;
  logic        busy;

  pea_result_drain dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .result_pop   (result_pop),
    .status_pop   (status_pop),
    .result_dout  (result_dout),
    .status_dout  (status_dout),
    .rd_en_result (rd_en_result),
    .rd_en_status (rd_en_status),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_seq      (out_seq),
    .err_count    (err_count),
    .desync       (desync),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  seq;
    logic [7:0]  err;
  } exp_t;

  // Reference model: two FIFOs and the expected output stream.
  logic [15:0] rq[$];
  logic [15:0] sq[$];
  exp_t        sb[$];
  int          pushed;
  int          nz;
  int          force_pops;
  int          rdy_mode;

  int n_cmp = 0;
  int n_bad = 0;

  // Monitor-owned state.
  int          rd_idx;
  int          mon_pops;
  int          mon_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // New word enters both FIFOs; its expected delivery follows from delivery order.
  task automatic push_word(input logic [15:0] r, input logic [15:0] s);
    exp_t e;
    rq.push_back(r);
    sq.push_back(s);
    if (s != 16'h0) nz++;
    e.data = {s, r};
    e.seq  = 8'(pushed);
    e.err  = (nz > 255) ? 8'd255 : 8'(nz);
    sb.push_back(e);
    pushed++;
  endtask

  // One clock: FIFO read model, pop-count outputs, consumer readiness.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rd_en_result) result_dout = (rq.size() > 0) ? rq.pop_front() : 16'hdead;
    if (rd_en_status) status_dout = (sq.size() > 0) ? sq.pop_front() : 16'hdead;
    if (force_pops == 0) begin
      result_pop = (rq.size() > 31) ? 5'd31 : 5'(rq.size());
      status_pop = (sq.size() > 31) ? 5'd31 : 5'(sq.size());
    end
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic do_reset();
    rst = 1'b0;
    en = 1'b0;
    force_pops = 0;
    rdy_mode = 0;
    rq.delete();
    sq.delete();
    sb.delete();
    pushed = 0;
    nz = 0;
    result_pop = '0;
    status_pop = '0;
    result_dout = '0;
    status_dout = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
  endtask

  task automatic wait_acc(input string name, input int n, input int bound);
    int g;
    g = 0;
    while (mon_acc < n && g < bound) begin
      tick();
      g++;
    end
    chk(name, 32'(mon_acc), 32'(n));
  endtask

  // Monitor: checks every accepted word against the scoreboard, latency and hold stability.
  initial begin
    int          cyc;
    int          pop_cyc;
    logic        prev_vld;
    logic        prev_acc;
    logic [31:0] prev_data;
    logic [7:0]  prev_seq;
    logic        err_pending;
    logic [7:0]  err_exp;
    cyc = 0; pop_cyc = 0; prev_vld = 0; prev_acc = 0; prev_data = '0; prev_seq = '0;
    err_pending = 0; err_exp = '0; rd_idx = 0; mon_pops = 0; mon_acc = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        rd_idx = 0; mon_pops = 0; mon_acc = 0; prev_vld = 0; prev_acc = 0;
        err_pending = 0; cyc = 0;
      end else begin
        cyc++;
        if (err_pending) begin
          chk("err_count", 32'(err_count), 32'(err_exp));
          err_pending = 0;
        end
        if (rd_en_result || rd_en_status) begin
          chk("rd_en_pair", 32'(rd_en_result), 32'(rd_en_status));
          mon_pops++;
          pop_cyc = cyc;
        end
        if (out_valid && !prev_vld) chk("latency", 32'(cyc - pop_cyc), 32'd2);
        if (out_valid && prev_vld && !prev_acc) begin
          chk("hold_data", out_data, prev_data);
          chk("hold_seq", 32'(out_seq), 32'(prev_seq));
        end
        if (out_valid && out_ready) begin
          if (rd_idx >= sb.size()) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_word: got %0h expected none", out_data);
          end else begin
            chk("out_data", out_data, sb[rd_idx].data);
            chk("out_seq", 32'(out_seq), 32'(sb[rd_idx].seq));
            err_exp = sb[rd_idx].err;
            err_pending = 1;
            rd_idx++;
          end
          mon_acc++;
        end
        prev_vld  = out_valid;
        prev_acc  = out_valid && out_ready;
        prev_data = out_data;
        prev_seq  = out_seq;
      end
    end
  end

  initial begin
    rst = 1'b0; en = 1'b0; result_pop = '0; status_pop = '0;
    result_dout = '0; status_dout = '0; out_ready = 1'b0;
    force_pops = 0; rdy_mode = 0; pushed = 0; nz = 0;

    // 1: reset held with inputs toggling.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      en          = 1'($urandom_range(0, 1));
      result_pop  = 5'($urandom_range(0, 31));
      status_pop  = 5'($urandom_range(0, 31));
      result_dout = 16'($urandom);
      status_dout = 16'($urandom);
      out_ready   = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_out_seq", 32'(out_seq), 32'd0);
      chk("rst_err_count", 32'(err_count), 32'd0);
      chk("rst_desync", 32'(desync), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rd_en", 32'({rd_en_result, rd_en_status}), 32'd0);
    end
    do_reset();

    // 2: single word.
    en = 1'b1;
    rdy_mode = 1;
    push_word(16'h0042, 16'h0000);
    wait_acc("single_acc", 1, 50);
    repeat (3) tick();
    chk("single_pops", 32'(mon_pops), 32'd1);
    chk("single_err", 32'(err_count), 32'd0);
    chk("single_busy", 32'(busy), 32'd0);

    // 3: backpressure with three queued words.
    do_reset();
    en = 1'b1;
    rdy_mode = 0;
    for (int i = 0; i < 3; i++) push_word(16'h1000 + 16'(i), 16'h0000);
    repeat (12) tick();
    chk("bp_pops_stalled", 32'(mon_pops), 32'd1);
    chk("bp_valid_held", 32'(out_valid), 32'd1);
    chk("bp_data_held", out_data, 32'h0000_1000);
    rdy_mode = 1;
    wait_acc("bp_acc", 3, 60);
    repeat (3) tick();
    chk("bp_pops_total", 32'(mon_pops), 32'd3);

    // 4: 260 words with nonzero status, random readiness: seq wraps, err_count saturates.
    do_reset();
    en = 1'b1;
    rdy_mode = 2;
    begin
      int g;
      g = 0;
      while (pushed < 260 && g < 5000) begin
        if (rq.size() < 20) push_word(16'($urandom), 16'h0001);
        tick();
        g++;
      end
    end
    wait_acc("wrap_acc", 260, 5000);
    repeat (2) tick();
    chk("wrap_err_sat", 32'(err_count), 32'd255);
    chk("wrap_seq_next", 32'(out_seq), 32'd4);

    // 5: desync after 16 mismatch cycles, then permanent lockout.
    do_reset();
    en = 1'b1;
    rdy_mode = 1;
    force_pops = 1;
    result_pop = 5'd2;
    status_pop = 5'd0;
    repeat (15) tick();
    chk("desync_before_limit", 32'(desync), 32'd0);
    tick();
    chk("desync_at_limit", 32'(desync), 32'd1);
    status_pop = 5'd2;
    repeat (10) tick();
    chk("desync_sticky", 32'(desync), 32'd1);
    chk("desync_no_pops", 32'(mon_pops), 32'd0);
    chk("desync_idle", 32'(busy), 32'd0);

    // 6: enable gating.
    do_reset();
    rdy_mode = 1;
    en = 1'b0;
    for (int i = 0; i < 4; i++) push_word(16'h2000 + 16'(i), 16'(i));
    repeat (10) tick();
    chk("en_low_pops", 32'(mon_pops), 32'd0);
    en = 1'b1;
    tick();
    en = 1'b0;
    repeat (20) tick();
    chk("en_pulse_pops", 32'(mon_pops), 32'd1);
    chk("en_pulse_acc", 32'(mon_acc), 32'd1);

    // 7: random statuses, random enable and readiness.
    do_reset();
    rdy_mode = 2;
    begin
      int g;
      g = 0;
      while (pushed < 100 && g < 5000) begin
        if (rq.size() < 10) push_word(16'($urandom), ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'h0);
        en = ($urandom_range(0, 3) != 0);
        tick();
        g++;
      end
    end
    en = 1'b1;
    wait_acc("rand_acc", 100, 3000);
    repeat (2) tick();
    chk("rand_err", 32'(err_count), 32'((nz > 255) ? 255 : nz));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
